// File: rtl/if_id_if.sv
// Fetch/decode boundary bundle: PC-stage fetch side in,
// decode-stage register and event counters out.
interface if_id_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      pc;
  logic             im_en;
  logic [31:0]      im_rdata;
  logic             stall;
  logic             flush;
  logic [31:0]      id_pc;
  logic [31:0]      id_pc4;
  logic [31:0]      id_instr;
  logic             id_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output pc, im_en, im_rdata, stall, flush,
    input  id_pc, id_pc4, id_instr, id_valid,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  pc, im_en, im_rdata, stall, flush,
    output id_pc, id_pc4, id_instr, id_valid,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: pairs each fetch PC with its
// 1-cycle-late IM word, with skid buffer for stalls.
module if_id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input logic clk,
  input logic rstn,
  if_id_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]      f_pc;
  logic             f_valid;
  logic [31:0]      f_buf;
  logic             f_buf_v;
  logic [31:0]      f_instr;
  logic [31:0]      id_pc;
  logic [31:0]      id_pc4;
  logic [31:0]      id_instr;
  logic             id_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Once captured, the skid word wins over the live IM port,
  // which by then already shows the next address's data.
  assign f_instr = f_buf_v ? f_buf : bus.im_rdata;

  // F slot and skid buffer: flush squashes, stall captures once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      f_pc    <= 32'h0;
      f_valid <= 1'b0;
      f_buf   <= 32'h0;
      f_buf_v <= 1'b0;
    end else begin
      priority case (1'b1)
        bus.flush: begin
          f_pc    <= bus.pc;
          f_valid <= 1'b0;
          f_buf_v <= 1'b0;
        end
        bus.stall: begin
          if (f_valid && !f_buf_v) begin
            f_buf   <= bus.im_rdata;
            f_buf_v <= 1'b1;
          end
        end
        default: begin
          f_pc    <= bus.pc;
          f_valid <= bus.im_en;
          f_buf_v <= 1'b0;
        end
      endcase
    end
  end

  // ID register: bubble on flush, hold on stall, else load F slot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_pc    <= 32'h0;
      id_pc4   <= 32'h4;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else begin
      priority case (1'b1)
        bus.flush: begin
          id_instr <= NOP_INSTR;
          id_valid <= 1'b0;
        end
        bus.stall: begin
        end
        default: begin
          id_pc    <= f_pc;
          id_pc4   <= f_pc + 32'd4;
          id_instr <= f_valid ? f_instr : NOP_INSTR;
          id_valid <= f_valid;
        end
      endcase
    end
  end

  // Saturating event counters; a flush cycle is never a stall cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.stall && !bus.flush && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      if (bus.flush && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.id_pc     = id_pc;
  assign bus.id_pc4    = id_pc4;
  assign bus.id_instr  = id_instr;
  assign bus.id_valid  = id_valid;
  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;
endmodule
